// File: rtl/piso_stream_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out streamer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter width for a range of n values; a single value still needs one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/piso_stream_if.sv
// Producer-side handshake and serial-side outputs of piso_stream.
interface piso_stream_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] pi;
  logic             msb_first;
  logic             ready;
  logic             so;
  logic             so_valid;
  logic             so_first;
  logic             so_last;
  logic             busy;
  logic             drop;

  // The streamer itself
  modport slave (
    input  load, pi, msb_first,
    output ready, so, so_valid, so_first, so_last, busy, drop
  );

  // The producer / line monitor
  modport master (
    output load, pi, msb_first,
    input  ready, so, so_valid, so_first, so_last, busy, drop
  );
endinterface

// File: rtl/piso_stream_bit_tick_gen.sv
// Divider for the serial bit period: tick marks the last cycle of each bit.
module bit_tick_gen
  import piso_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int            DW   = cnt_width(DIV);
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt;

  // Count 0..DIV-1 and wrap; held at zero while no frame is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (clr || (div_cnt == LAST)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == LAST);
endmodule

// File: rtl/piso_stream.sv
// Parameterised PISO: one-word holding buffer feeding a shifter, gap-free
// back-to-back frames, per-word bit order and first/last framing strobes.
module piso_stream
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic            clk,
  input  logic            rst,
  piso_stream_if.slave    bus
);
  localparam int            BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] hold;
  logic             hold_dir;
  logic             hold_full;
  logic [WIDTH-1:0] shreg;
  logic             dir;
  logic [BW-1:0]    bit_cnt;
  logic             drop_reg;

  logic tick;
  logic accept;
  logic xfer;
  logic shift_en;

  // Hold can only take a word when empty, so accept and transfer never coincide.
  assign accept = bus.load && !hold_full;

  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state plus transfer/shift strobes for the datapath.
  always_comb begin
    state_next = state;
    xfer       = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          xfer       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (bit_cnt != LAST_BIT) shift_en = 1'b1;
          else if (hold_full)      xfer = 1'b1;
          else                     state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Holding buffer, shifter, bit counter and the rejected-load pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_dir  <= 1'b0;
      hold_full <= 1'b0;
      shreg     <= '0;
      dir       <= 1'b0;
      bit_cnt   <= '0;
      drop_reg  <= 1'b0;
    end else begin
      drop_reg <= bus.load && hold_full;

      if (accept) begin
        hold      <= bus.pi;
        hold_dir  <= bus.msb_first;
        hold_full <= 1'b1;
      end else if (xfer) begin
        hold_full <= 1'b0;
      end

      if (xfer) begin
        shreg   <= hold;
        dir     <= hold_dir;
        bit_cnt <= '0;
      end else if (shift_en) begin
        shreg   <= dir ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign bus.so       = (state == SHIFT) && (dir ? shreg[WIDTH-1] : shreg[0]);
  assign bus.so_valid = (state == SHIFT);
  assign bus.so_first = (state == SHIFT) && (bit_cnt == '0);
  assign bus.so_last  = (state == SHIFT) && (bit_cnt == LAST_BIT);
  assign bus.busy     = (state == SHIFT) || hold_full;
  assign bus.ready    = !hold_full;
  assign bus.drop     = drop_reg;
endmodule

// File: doc/piso_stream.md
# piso_stream

Parametrised parallel-in/serial-out shifter, successor to the fixed 8-bit PISO. It accepts WIDTH-bit words through a load/ready handshake into a one-word holding buffer and shifts them out one bit per DIV clock cycles, with a runtime-selectable bit order per word. It emits framing strobes for the first and last bit and streams back-to-back words with no idle gap. It sits between a parallel producer (register file or FIFO) and a serial line driver.

## Interface
- WIDTH, 8, word width in bits; must be ≥2.
- DIV, 1, clock cycles per serial bit; must be ≥1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  word-valid request; the word is accepted on an edge where load && ready.
- pi  in  WIDTH  parallel word; sampled only on acceptance.
- msb_first  in  1  bit order for the word being loaded (1 = MSB first); sampled with pi.
- ready  out  1  holding buffer empty; safe to load.
- so  out  1  serial data bit.
- so_valid  out  1  so carries a data bit.
- so_first  out  1  current bit is bit 0 of the frame.
- so_last  out  1  current bit is the final bit of the frame.
- busy  out  1  shifting, or holding buffer full.
- drop  out  1  one-cycle pulse: a load was presented while ready was low, and that word was discarded.

## Operation
- Storage: a holding register (hold, hold_dir, hold_full), a shift register (shreg, dir), a bit counter (0..WIDTH-1) and a divider counter (0..DIV-1).
- ready = !hold_full. On an edge with load && ready, pi and msb_first are written into the holding register and hold_full is set.
- A load with !ready leaves all state unchanged. drop is asserted for exactly the next cycle.
- FSM states:
  - IDLE: so=0, so_valid=0, so_first=0, so_last=0. If hold_full: on the next edge, transfer hold to shreg, clear hold_full, set bit_cnt=0 and div_cnt=0, and go to SHIFT.
  - SHIFT:
    - so = dir ? shreg[WIDTH-1] : shreg[0]; so_valid=1.
    - so_first = (bit_cnt==0); so_last = (bit_cnt==WIDTH-1).
    - Each edge: if div_cnt<DIV-1, increment div_cnt. Otherwise clear div_cnt, then:
      - If bit_cnt<WIDTH-1: shift shreg toward the output end and increment bit_cnt.
      - Else if hold_full: reload from hold, clear hold_full, set bit_cnt=0, stay in SHIFT.
      - Else: go to IDLE.
- Accept and transfer are never simultaneous: accept requires hold_full=0, transfer requires hold_full=1.
- Word bit order is latched per word, so changing msb_first mid-frame has no effect on the word in flight.
- busy = (state==SHIFT) || hold_full.
- All outputs derive from registers only; there is no combinational path from input to output.
- Reset, whether idle or mid-frame, clears all state immediately:
  - state=IDLE, hold_full=0, counters=0, shreg=0.
  - Outputs: so=0, so_valid=0, so_first=0, so_last=0, busy=0, drop=0, ready=1.
  - Any partial frame is discarded.

## Timing
- Latency: load accepted at edge E → SHIFT entered at edge E+1 → first bit on so during the cycle after E+1.
- Each bit is held for DIV cycles. A frame lasts WIDTH×DIV cycles.
- Gap-free streaming: when the next word is accepted before the final divider tick of the last bit, so_valid stays high continuously across frames. so_last of frame n is immediately followed by so_first of frame n+1.
- ready falls the cycle after acceptance. It rises the cycle after the transfer into shreg.
- drop rises the cycle after the rejected load edge and lasts one cycle.

## Structure
- Shared package piso_pkg:
  - state enum {IDLE, SHIFT};
  - counter-width helper, $clog2 with a minimum of 1 applied to WIDTH and DIV.
- Sub-module bit_tick_gen (parameter DIV): holds the divider counter and outputs a tick on div_cnt==DIV-1. It is cleared by rst and by frame start.
- Holding buffer, shifter and FSM live in piso_stream.

## Test plan
- WIDTH=8, DIV=1, rst released, load 0xC6 with msb_first=1 → so = 1,1,0,0,0,1,1,0 over 8 consecutive so_valid cycles, beginning the cycle after E+1. so_first is high on the first bit, so_last on the eighth, then the block returns to idle with so=0.
- Same setup, 0xC6 with msb_first=0 → so = 0,1,1,0,0,0,1,1.
- Load 0xC6 then 0x3F (msb_first=1) as soon as ready is high → so_valid high for 16 contiguous cycles, with so = 11000110 followed by 00111111 and no gap between frames.
- DIV=4, load 0xA5 (msb_first=1) → each bit held 4 cycles, 32-cycle frame; so_last is high for the final 4 cycles.
- Load 0x11, then 0x22 while shifting, then 0x33 while ready=0 → drop pulses once, and the output is 0x11 then 0x22; 0x33 never appears.
- Assert rst during bit 3 of a frame, with a word pending in hold → all outputs go to reset values immediately and ready=1. After release the block stays idle until a new load.
